// File: rtl/dma_stream_fifo.sv
// Stream FIFO ahead of the DMA S2MM port: FWFT output over a registered-read RAM,
// with byte occupancy, high-water mark and overflow-attempt counters.
module dma_stream_fifo #(
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [C_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             fifo_occupancy,
  output logic [31:0]             peak_occupancy,
  output logic [31:0]             overflow_attempts
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = C_AXIS_WIDTH + 1;
  localparam logic [31:0] BYTES = 32'(C_AXIS_WIDTH / 8);

  logic [DW-1:0] mem [C_DEPTH];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] byp_q;
  logic [DW-1:0] head;
  logic [DW-1:0] in_word;
  logic          byp_sel;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tready_q;
  logic          m_valid_q;
  logic          push;
  logic          pop;
  logic          load_in;
  logic          ram_wr;
  logic          ram_pop;

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = m_valid_q;
  assign in_word       = {s_axis_tlast, s_axis_tdata};

  // The output register holds the oldest beat; the RAM holds the rest.
  always_comb begin
    push    = s_axis_tvalid & tready_q & ~flush;
    pop     = m_valid_q & m_axis_tready & ~flush;
    load_in = push & ((cnt == '0) | ((cnt == CW'(1)) & pop));
    ram_wr  = push & ~load_in;
    ram_pop = pop & (cnt > CW'(1));
    rd_nxt  = rd_ptr + AW'(ram_pop);
    head    = byp_sel ? byp_q : ram_q;
    cnt_nxt = cnt;
    if (push & ~pop)
      cnt_nxt = cnt + CW'(1);
    else if (pop & ~push)
      cnt_nxt = cnt - CW'(1);
  end

  // Read address runs one ahead so ram_q always shows the RAM head.
  always_ff @(posedge clk) begin
    if (ram_wr)
      mem[wr_ptr] <= in_word;
    ram_q <= mem[rd_nxt];
    if (ram_wr)
      byp_q <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tready_q       <= 1'b0;
      m_valid_q      <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      byp_sel        <= 1'b0;
      fifo_occupancy <= '0;
      peak_occupancy <= '0;
    end else if (flush) begin
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tready_q       <= 1'b0;
      m_valid_q      <= 1'b0;
      byp_sel        <= 1'b0;
      fifo_occupancy <= '0;
      peak_occupancy <= '0;
    end else begin
      cnt       <= cnt_nxt;
      wr_ptr    <= wr_ptr + AW'(ram_wr);
      rd_ptr    <= rd_nxt;
      tready_q  <= (cnt_nxt != CW'(C_DEPTH));
      m_valid_q <= (cnt_nxt != '0);
      if (load_in)
        {m_axis_tlast, m_axis_tdata} <= in_word;
      else if (ram_pop)
        {m_axis_tlast, m_axis_tdata} <= head;
      // A write landing on the address being read returns stale data.
      byp_sel        <= ram_wr & (wr_ptr == rd_nxt);
      fifo_occupancy <= 32'(cnt) * BYTES;
      if (fifo_occupancy > peak_occupancy)
        peak_occupancy <= fifo_occupancy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow_attempts <= '0;
    else if (s_axis_tvalid && !tready_q && overflow_attempts != '1)
      overflow_attempts <= overflow_attempts + 32'd1;
  end

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Directed and randomized checks of dma_stream_fifo with a 16-deep, 64-bit FIFO.
module tb_dma_stream_fifo;

  localparam int W = 64;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [31:0]  occ;
  logic [31:0]  peak;
  logic [31:0]  ovf;

  int checks = 0;
  int failures = 0;

  logic [W:0] q[$];

  always #5 clk = ~clk;

  dma_stream_fifo #(
    .C_AXIS_WIDTH(W),
    .C_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .fifo_occupancy(occ),
    .peak_occupancy(peak),
    .overflow_attempts(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic tv);
    rst = 1'b1;
    flush = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    tick();
    rst = 1'b0;
    s_tvalid = tv;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({s_tready, m_tvalid, m_tlast} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000", {s_tready, m_tvalid, m_tlast});
    end
    checks++;
    if (m_tdata !== '0) begin
      failures++;
      $display("FAIL rst_tdata got=%h exp=0", m_tdata);
    end
    checks++;
    if ({occ, peak, ovf} !== '0) begin
      failures++;
      $display("FAIL rst_counters got=%h/%h/%h exp=0", occ, peak, ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_tready_rise got=%b exp=1", s_tready);
    end
  endtask

  task automatic test_fill_hold();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = 64'hA;
    s_tlast = 1'b0;
    tick();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 64'hA) begin
      failures++;
      $display("FAIL fwft_first got=%b/%h exp=1/a", m_tvalid, m_tdata);
    end
    s_tdata = 64'hB;
    tick();
    s_tdata = 64'hC;
    s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    tick();
    checks++;
    if (occ !== 32'd24) begin
      failures++;
      $display("FAIL occ_three got=%0d exp=24", occ);
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 64'hA || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL hold_a got=%b/%h/%b exp=1/a/0", m_tvalid, m_tdata, m_tlast);
    end
    m_tready = 1'b1;
    tick();
    checks++;
    if (m_tdata !== 64'hB || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL pop_b got=%h/%b exp=b/0", m_tdata, m_tlast);
    end
    tick();
    checks++;
    if (m_tdata !== 64'hC || m_tlast !== 1'b1) begin
      failures++;
      $display("FAIL pop_c got=%h/%b exp=c/1", m_tdata, m_tlast);
    end
    tick();
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL empty_valid got=%b exp=0", m_tvalid);
    end
    checks++;
    if (peak !== 32'd24) begin
      failures++;
      $display("FAIL peak_24 got=%0d exp=24", peak);
    end
  endtask

  task automatic test_full();
    int pushed = 0;
    do_reset(1'b0);
    q.delete();
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 64'h100 + 64'(pushed);
      if (s_tready) begin
        q.push_back({1'b0, s_tdata});
        pushed++;
      end
      tick();
    end
    s_tvalid = 1'b0;
    checks++;
    if (pushed != 16 || s_tready !== 1'b0) begin
      failures++;
      $display("FAIL full_accept got=%0d/%b exp=16/0", pushed, s_tready);
    end
    checks++;
    if (occ !== 32'd128) begin
      failures++;
      $display("FAIL full_occ got=%0d exp=128", occ);
    end
    checks++;
    if (ovf !== 32'd4) begin
      failures++;
      $display("FAIL full_ovf got=%0d exp=4", ovf);
    end
  endtask

  task automatic test_wrap();
    int nxt = 16;
    logic [W:0] e;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    checks++;
    if (s_tready !== 1'b0) begin
      failures++;
      $display("FAIL no_passthru got=%b exp=0", s_tready);
    end
    for (int c = 0; c < 40; c++) begin
      s_tdata = 64'h100 + 64'(nxt);
      checks++;
      if (m_tvalid !== 1'b1 || q.size() == 0) begin
        failures++;
        $display("FAIL wrap_bubble cyc=%0d got=%b exp=1", c, m_tvalid);
      end else begin
        e = q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL wrap_order cyc=%0d got=%h exp=%h", c, m_tdata, e[W-1:0]);
        end
      end
      if (s_tready) begin
        q.push_back({1'b0, s_tdata});
        nxt++;
      end
      tick();
    end
    s_tvalid = 1'b0;
    checks++;
    if (occ !== 32'd120) begin
      failures++;
      $display("FAIL wrap_steady_occ got=%0d exp=120", occ);
    end
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      e = q.pop_front();
      checks++;
      if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== e) begin
        failures++;
        $display("FAIL wrap_drain got=%b/%h exp=1/%h", m_tvalid, m_tdata, e[W-1:0]);
      end
      tick();
    end
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || q.size() != 0) begin
      failures++;
      $display("FAIL wrap_end got=%b/%0d exp=0/0", m_tvalid, q.size());
    end
  endtask

  task automatic test_flush();
    s_tdata = 64'h200;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      s_tdata = 64'h200 + 64'(i);
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (occ !== 32'd80 || ovf !== 32'd1) begin
      failures++;
      $display("FAIL pre_flush got=%0d/%0d exp=80/1", occ, ovf);
    end
    flush = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 64'h2FF;
    m_tready = 1'b1;
    tick();
    flush = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    checks++;
    if (occ !== 32'd0 || peak !== 32'd0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got=%0d/%0d/%b exp=0/0/0", occ, peak, m_tvalid);
    end
    checks++;
    if (ovf !== 32'd1) begin
      failures++;
      $display("FAIL flush_ovf got=%0d exp=1", ovf);
    end
    tick();
    s_tvalid = 1'b1;
    s_tdata = 64'h300;
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 64'h300) begin
      failures++;
      $display("FAIL flush_next got=%b/%h exp=1/300", m_tvalid, m_tdata);
    end
    tick();
    checks++;
    if (occ !== 32'd8) begin
      failures++;
      $display("FAIL flush_occ8 got=%0d exp=8", occ);
    end
  endtask

  task automatic test_mid_reset();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_tdata = 64'h400 + 64'(i);
      tick();
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({s_tready, m_tvalid, m_tlast} !== 3'b000 || m_tdata !== '0) begin
      failures++;
      $display("FAIL midrst_out got=%b/%h exp=000/0", {s_tready, m_tvalid, m_tlast}, m_tdata);
    end
    checks++;
    if ({occ, peak, ovf} !== '0) begin
      failures++;
      $display("FAIL midrst_cnt got=%h/%h/%h exp=0", occ, peak, ovf);
    end
    rst = 1'b0;
    tick();
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = 64'h500 + 64'(i);
      s_tlast = (i == 2);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 64'h500 + 64'(i) || m_tlast !== (i == 2)) begin
        failures++;
        $display("FAIL midrst_pkt beat=%0d got=%b/%h/%b", i, m_tvalid, m_tdata, m_tlast);
      end
      tick();
    end
    m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_empty got=%b exp=0", m_tvalid);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int cyc = 0;
    int sz;
    logic [W:0] e;
    do_reset(1'b0);
    q.delete();
    while ((pushed < 10000 || q.size() != 0) && cyc < 60000) begin
      s_tvalid = (pushed < 10000) && ($urandom_range(0, 3) != 0);
      s_tdata = {$urandom, $urandom};
      s_tlast = 1'($urandom_range(0, 1));
      m_tready = ($urandom_range(0, 3) != 0);
      sz = q.size();
      checks++;
      if (m_tvalid !== (sz != 0) || s_tready !== (sz < D)) begin
        failures++;
        $display("FAIL rnd_flags cyc=%0d got=%b/%b cnt=%0d", cyc, m_tvalid, s_tready, sz);
      end
      if (m_tvalid && m_tready && sz != 0) begin
        e = q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL rnd_data cyc=%0d got=%b/%h exp=%h", cyc, m_tlast, m_tdata, e);
        end
      end
      if (s_tvalid && s_tready) begin
        q.push_back({s_tlast, s_tdata});
        pushed++;
      end
      tick();
      cyc++;
      checks++;
      if (occ !== 32'(sz * 8)) begin
        failures++;
        $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, occ, sz * 8);
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    checks++;
    if (cyc >= 60000) begin
      failures++;
      $display("FAIL rnd_timeout pushed=%0d left=%0d", pushed, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill_hold();
    test_full();
    test_wrap();
    test_flush();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_stream_fifo.md
DMA_STREAM_FIFO -- requirements
Module: dma_stream_fifo

Interface
REQ-001 The block SHALL have parameter C_AXIS_WIDTH, default 64, giving the stream data width in bits; legal values are 32, 64 and 128.
REQ-002 The block SHALL have parameter C_DEPTH, default 512, giving the storage capacity in words; legal values are powers of two from 16 to 4096.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; one clock, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all stored data; driven from the DMA engine's dm_rst_n, inverted.
REQ-006 The block SHALL have port s_axis_tdata, input, C_AXIS_WIDTH bits: upstream data.
REQ-007 The block SHALL have port s_axis_tlast, input, 1 bit: upstream end-of-packet.
REQ-008 The block SHALL have port s_axis_tvalid, input, 1 bit: upstream valid.
REQ-009 The block SHALL have port s_axis_tready, output, 1 bit: upstream ready.
REQ-010 The block SHALL have port m_axis_tdata, output, C_AXIS_WIDTH bits: data to the DMA engine's s_axis_s2mm.
REQ-011 The block SHALL have port m_axis_tlast, output, 1 bit: end-of-packet to the DMA engine.
REQ-012 The block SHALL have port m_axis_tvalid, output, 1 bit: valid to the DMA engine.
REQ-013 The block SHALL have port m_axis_tready, input, 1 bit: ready from the DMA engine.
REQ-014 The block SHALL have port fifo_occupancy, output, 32 bits: stored bytes; connects to the DMA engine's fifo_occupancy.
REQ-015 The block SHALL have port peak_occupancy, output, 32 bits: high-water mark in bytes since the last reset or flush.
REQ-016 The block SHALL have port overflow_attempts, output, 32 bits: count of cycles with s_axis_tvalid=1 and s_axis_tready=0.

Function
REQ-017 The block SHALL store a beat as tdata plus tlast; a beat is pushed when s_axis_tvalid and s_axis_tready are both 1.
REQ-018 A beat SHALL be popped when m_axis_tvalid and m_axis_tready are both 1.
REQ-019 The block SHALL keep a word count cnt, clog2(C_DEPTH)+1 bits wide, updated each cycle as: push only +1; pop only -1; push and pop together 0.
REQ-020 s_axis_tready SHALL be 1 exactly when cnt < C_DEPTH and rst=0 and flush=0, registered so it reflects the previous cycle's count.
REQ-021 There SHALL be no pass-through when full: at cnt = C_DEPTH, tready is 0 even if a pop occurs in the same cycle.
REQ-022 The output SHALL be first-word-fall-through: a beat pushed at edge N SHALL give m_axis_tvalid=1 with that beat's data at cycle N+1 if the FIFO was empty.
REQ-023 Beats SHALL leave in strict push order with tlast preserved bit-exact.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL hold stable.
REQ-025 m_axis_tvalid SHALL be 0 exactly when cnt=0.
REQ-026 fifo_occupancy SHALL equal cnt*(C_AXIS_WIDTH/8), registered and zero-extended to 32 bits, updated the cycle after the push or pop.
REQ-027 peak_occupancy SHALL be updated to fifo_occupancy whenever fifo_occupancy exceeds it.
REQ-028 overflow_attempts SHALL saturate at 0xFFFFFFFF and SHALL NOT be cleared by flush.
REQ-029 Read and write pointers SHALL be log2(C_DEPTH) bits and wrap modulo C_DEPTH without a bubble at the wrap point.
REQ-030 On flush=1, at the next edge cnt, both pointers, fifo_occupancy and peak_occupancy SHALL become 0 and m_axis_tvalid SHALL become 0.
REQ-031 During flush, input beats SHALL be refused and the flush cycle's push and pop SHALL be ignored.
REQ-032 Storage SHALL be inferable as simple dual-port block RAM with a registered read port; a prefetch/output register stage SHALL hide RAM read latency.
REQ-033 cnt SHALL count the beat held in the output stage.

Reset
REQ-034 At the edge where rst=1, the block SHALL clear cnt, the pointers, fifo_occupancy, peak_occupancy and overflow_attempts to 0.
REQ-035 At that edge, s_axis_tready, m_axis_tvalid and m_axis_tlast SHALL be cleared to 0.
REQ-036 At that edge, m_axis_tdata SHALL be cleared to 0.
REQ-037 s_axis_tready SHALL rise on the first cycle after rst deasserts.
REQ-038 Reset asserted mid-packet SHALL discard partial packets with no tlast fix-up.
REQ-039 RAM contents SHALL NOT require reset.

Verification
REQ-040 Scenario: push 3 beats 0xA,0xB,0xC (tlast on 0xC) with C_AXIS_WIDTH=64 and m_axis_tready=0 -> m_axis_tvalid rises one cycle after the first push; fifo_occupancy reaches 24; tdata is held at 0xA.
REQ-041 Scenario: with C_DEPTH=16, push continuously with m_axis_tready=0 -> tready drops after 16 beats; fifo_occupancy=128; overflow_attempts increments once per stalled-valid cycle.
REQ-042 Scenario: from full, assert m_axis_tready=1 and s_axis_tvalid=1 for 40 cycles -> no pass-through at full; afterwards beats arrive in order across a pointer wrap with no bubbles and occupancy stays constant in steady state.
REQ-043 Scenario: pulse flush for 1 cycle with 10 beats stored -> next cycle fifo_occupancy=0, peak_occupancy=0, m_axis_tvalid=0; overflow_attempts is unchanged; the next pushed beat emerges first.
REQ-044 Scenario: assert rst mid-packet with 5 beats stored -> all outputs and counters are 0; the following packet is intact.
REQ-045 Scenario: random tvalid/tready over 10k beats against a scoreboard -> there is no loss, duplication or reorder, and fifo_occupancy equals the model's count each cycle.
